spo2_ratio_calc: RTL

//  Consumes per-LED AC/DC magnitude pairs from the post-FFT data buffer.

---
 rtl/spo2_ratio_calc.sv | 135 +++++++++++++
 1 files changed

// File: rtl/spo2_ratio_calc.sv
// Ratio-of-ratios SpO2 estimator: R = (AC_red*DC_ir)/(AC_ir*DC_red) via a bit-serial
// restoring divider, then a linear calibration map clamped to 0..100 %.
module spo2_ratio_calc #(
   parameter int unsigned AW        = 22,
   parameter int unsigned FRAC_BITS = 10,
   parameter int unsigned R_W       = 16,
   parameter int unsigned SPO2_A    = 110,
   parameter int unsigned SPO2_B    = 25
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           new_comp_DV,
   input  logic           comp_led_sel,
   input  logic [AW-1:0]  AC_component,
   input  logic [AW-1:0]  DC_component,
   output logic [R_W-1:0] ratio_R,
   output logic [6:0]     spo2_pct,
   output logic           spo2_dv,
   output logic           div_zero,
   output logic           overrun,
   output logic           busy
);

   localparam int unsigned NUM_W = 2 * AW + FRAC_BITS;
   localparam int unsigned DEN_W = 2 * AW;
   localparam int unsigned CNT_W = $clog2(NUM_W + 1);
   localparam int unsigned T_W   = R_W + 8;

   typedef enum logic [1:0] {StIdle, StMult, StDiv, StMap} state_t;

   state_t           state_q;
   logic [AW-1:0]    red_ac_q, red_dc_q, ir_ac_q, ir_dc_q;
   logic             red_valid_q;
   logic [NUM_W-1:0] num_q;   // numerator, shifted out MSB first while quotient shifts in
   logic [DEN_W-1:0] den_q;
   logic [DEN_W-1:0] rem_q;
   logic             dz_q;
   logic [CNT_W-1:0] cnt_q;

   logic [DEN_W:0]   rem_shift;
   logic [DEN_W-1:0] rem_sub;
   logic             rem_ge;
   logic [R_W-1:0]   r_sat;
   logic [T_W-1:0]   t_full, t_int, s_pos;
   logic [6:0]       pct;

   always_comb begin
      rem_shift = {rem_q, num_q[NUM_W-1]};
      rem_ge    = rem_shift >= {1'b0, den_q};
      rem_sub   = rem_shift[DEN_W-1:0] - den_q;
      r_sat     = (dz_q || (|num_q[NUM_W-1:R_W])) ? '1 : num_q[R_W-1:0];
      t_full    = T_W'(SPO2_B) * T_W'(r_sat);
      t_int     = t_full >> FRAC_BITS;
      s_pos     = '0;
      pct       = '0;
      if (t_int < T_W'(SPO2_A)) begin
         s_pos = T_W'(SPO2_A) - t_int;
         pct   = (s_pos > T_W'(100)) ? 7'd100 : s_pos[6:0];
      end
   end

   assign busy = (state_q != StIdle);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         red_ac_q    <= '0;
         red_dc_q    <= '0;
         ir_ac_q     <= '0;
         ir_dc_q     <= '0;
         red_valid_q <= 1'b0;
         num_q       <= '0;
         den_q       <= '0;
         rem_q       <= '0;
         dz_q        <= 1'b0;
         cnt_q       <= '0;
         ratio_R     <= '0;
         spo2_pct    <= '0;
         spo2_dv     <= 1'b0;
         div_zero    <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         spo2_dv  <= 1'b0;
         div_zero <= 1'b0;
         overrun  <= 1'b0;
         if (new_comp_DV && !comp_led_sel) begin
            red_ac_q    <= AC_component;
            red_dc_q    <= DC_component;
            red_valid_q <= 1'b1;
         end
         if (new_comp_DV && comp_led_sel && state_q != StIdle) begin
            overrun <= 1'b1;
         end
         unique case (state_q)
            StIdle: begin
               if (new_comp_DV && comp_led_sel && red_valid_q) begin
                  ir_ac_q     <= AC_component;
                  ir_dc_q     <= DC_component;
                  red_valid_q <= 1'b0;
                  state_q     <= StMult;
               end
            end
            StMult: begin
               num_q   <= {DEN_W'(red_ac_q) * DEN_W'(ir_dc_q), {FRAC_BITS{1'b0}}};
               den_q   <= DEN_W'(ir_ac_q) * DEN_W'(red_dc_q);
               cnt_q   <= '0;
               state_q <= StDiv;
            end
            StDiv: begin
               // Step 0 latches the zero-divisor flag and clears the remainder; NUM_W steps follow.
               if (cnt_q == '0) begin
                  dz_q  <= (den_q == '0);
                  rem_q <= '0;
               end else begin
                  rem_q <= rem_ge ? rem_sub : rem_shift[DEN_W-1:0];
                  num_q <= {num_q[NUM_W-2:0], rem_ge};
               end
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(NUM_W)) begin
                  state_q <= StMap;
               end
            end
            StMap: begin
               ratio_R  <= r_sat;
               spo2_pct <= pct;
               spo2_dv  <= 1'b1;
               div_zero <= dz_q;
               state_q  <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
